// File: rtl/turn_controller.sv
// turn_controller: game-level phase sequencer.
// Drives the phase code and turn number and waits for each phase owner's
// finished pulse. It decides win/lose/draw and registers the active phase's
// pixel stream. Optional watchdog: define PHASE_TIMEOUT_EN.
//
// Handshake: the controller enters a phase and pulses phase_start_out in that
// phase's first cycle. The owning block answers with a one-cycle finished pulse.
// A pulse is accepted only from the second cycle of the phase onward, and only
// from the block that owns the phase. busy inputs are status only.
module turn_controller #(
  parameter int          MAX_TURNS      = 10,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd6_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic        player_busy_in,
  input  logic        player_finished_in,
  input  logic        enemy_busy_in,
  input  logic        enemy_finished_in,
  input  logic        player_defeated_in,
  input  logic        enemy_defeated_in,
  input  logic [11:0] title_pixel_in,
  input  logic [11:0] player_pixel_in,
  input  logic [11:0] enemy_pixel_in,
  input  logic [11:0] result_pixel_in,
  output logic [3:0]  state_out,
  output logic [3:0]  turn_out,
  output logic        phase_start_out,
  output logic [1:0]  result_out,
  output logic        timeout_out,
  output logic [11:0] pixel_out
);

  typedef enum logic [3:0] {
    ST_TITLE  = 4'b0000,
    ST_PLAYER = 4'b0001,
    ST_RESULT = 4'b0010,
    ST_ENEMY  = 4'b1000
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;
  localparam logic [3:0] MAX_TURN_VAL = 4'(MAX_TURNS);

  state_t      state_q, state_d;
  logic [3:0]  turn_d;
  logic [1:0]  result_d;
  logic        phase_start_d, timeout_d;
  logic [11:0] pixel_d;
  logic        in_phase, phase_fin, timeout_fire, phase_done;
  logic [4:0]  turn_inc;

  // busy lines and the watchdog length are not needed for sequencing.
  logic unused_ok;
  assign unused_ok = &{1'b0, player_busy_in, enemy_busy_in, TIMEOUT_CYCLES};

  // The state register is itself the registered phase code.
  assign state_out = state_q;
  assign in_phase  = (state_q == ST_PLAYER) || (state_q == ST_ENEMY);

  // Finished pulse from the phase owner, ignored during the entry cycle.
  always_comb begin
    phase_fin = 1'b0;
    if (state_q == ST_PLAYER) phase_fin = player_finished_in && !phase_start_out;
    if (state_q == ST_ENEMY)  phase_fin = enemy_finished_in && !phase_start_out;
  end

`ifdef PHASE_TIMEOUT_EN
  logic [23:0] wd_cnt;

  // Watchdog counter: zero in a phase's entry cycle, then counts phase cycles.
  always_ff @(posedge clk) begin
    if (rst)                wd_cnt <= 24'd0;
    else if (phase_start_d) wd_cnt <= 24'd0;
    else if (in_phase)      wd_cnt <= wd_cnt + 24'd1;
  end

  assign timeout_fire = in_phase && (wd_cnt == TIMEOUT_CYCLES - 24'd1);
`else
  assign timeout_fire = 1'b0;
`endif

  assign phase_done = phase_fin || timeout_fire;
  assign turn_inc   = {1'b0, turn_out} + 5'd1;

  // Next-state and next-output decision for the phase sequencer.
  always_comb begin
    state_d       = state_q;
    turn_d        = turn_out;
    result_d      = result_out;
    phase_start_d = 1'b0;
    timeout_d     = timeout_out;
    if (phase_done && !phase_fin) timeout_d = 1'b1;
    case (state_q)
      ST_TITLE: begin
        if (start_in) begin
          state_d       = ST_PLAYER;
          turn_d        = 4'd0;
          result_d      = RES_NONE;
          timeout_d     = 1'b0;
          phase_start_d = 1'b1;
        end
      end
      ST_PLAYER: begin
        if (phase_done) begin
          if (enemy_defeated_in) begin
            state_d  = ST_RESULT;
            result_d = RES_WIN;
          end else begin
            state_d       = ST_ENEMY;
            phase_start_d = 1'b1;
          end
        end
      end
      ST_ENEMY: begin
        if (phase_done) begin
          if (player_defeated_in && enemy_defeated_in) begin
            state_d  = ST_RESULT;
            result_d = RES_DRAW;
          end else if (player_defeated_in) begin
            state_d  = ST_RESULT;
            result_d = RES_LOSE;
          end else if (enemy_defeated_in) begin
            state_d  = ST_RESULT;
            result_d = RES_WIN;
          end else if (turn_inc == 5'(MAX_TURNS)) begin
            state_d  = ST_RESULT;
            result_d = RES_DRAW;
            turn_d   = MAX_TURN_VAL;
          end else begin
            state_d       = ST_PLAYER;
            turn_d        = turn_inc[3:0];
            phase_start_d = 1'b1;
          end
        end
      end
      ST_RESULT: begin
        if (start_in) state_d = ST_TITLE;
      end
      default: state_d = ST_TITLE;
    endcase
  end

  // Pixel source follows the phase currently shown on state_out.
  always_comb begin
    pixel_d = title_pixel_in;
    case (state_q)
      ST_PLAYER: pixel_d = player_pixel_in;
      ST_ENEMY:  pixel_d = enemy_pixel_in;
      ST_RESULT: pixel_d = result_pixel_in;
      default:   pixel_d = title_pixel_in;
    endcase
  end

  // All outputs registered; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_TITLE;
      turn_out        <= 4'd0;
      phase_start_out <= 1'b0;
      result_out      <= RES_NONE;
      timeout_out     <= 1'b0;
      pixel_out       <= 12'h000;
    end else begin
      state_q         <= state_d;
      turn_out        <= turn_d;
      phase_start_out <= phase_start_d;
      result_out      <= result_d;
      timeout_out     <= timeout_d;
      pixel_out       <= pixel_d;
    end
  end

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
- Game-level phase sequencer; the initiator side of the phase handshake that sub-blocks (player, enemy) answer on their state_in/turn_in/busy_out/finished_out ports.
- Drives the phase code and turn number and waits for each phase owner's finished pulse.
- Decides win, lose or draw, and muxes the active phase's pixel stream to the display path.

Parameters:
- MAX_TURNS, 10, turn limit (1..15); reaching it ends the game as a draw.
- TIMEOUT_CYCLES, 24'd6_000_000, watchdog length in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_in  in  1  single-cycle start/confirm pulse (debounced button)
- player_busy_in  in  1  player block working
- player_finished_in  in  1  single-cycle pulse: player phase done
- enemy_busy_in  in  1  enemy block working
- enemy_finished_in  in  1  single-cycle pulse: enemy phase done
- player_defeated_in  in  1  level: player HP is zero
- enemy_defeated_in  in  1  level: enemy HP is zero
- title_pixel_in  in  12  title screen pixel
- player_pixel_in  in  12  player phase pixel
- enemy_pixel_in  in  12  enemy phase pixel
- result_pixel_in  in  12  result screen pixel
- state_out  out  4  phase code, broadcast to all sub-blocks
- turn_out  out  4  current turn number
- phase_start_out  out  1  one-cycle pulse in the first cycle of PLAYER or ENEMY
- result_out  out  2  00 none, 01 win, 10 lose, 11 draw
- timeout_out  out  1  sticky watchdog-fired flag
- pixel_out  out  12  registered pixel for the active phase

Behaviour:
- Phase codes:
  - TITLE = 4'b0000
  - PLAYER = 4'b0001
  - RESULT = 4'b0010
  - ENEMY = 4'b1000
- All outputs are registered.
- Reset values: state_out = TITLE, turn_out = 0, phase_start_out = 0, result_out = 00, timeout_out = 0, pixel_out = 12'h000.
- rst overrides everything, including a reset asserted mid-phase.
- TITLE: start_in -> PLAYER next cycle. turn_out := 0, result_out := 00, timeout_out := 0, phase_start_out := 1.
- PLAYER:
  - finished is accepted only from the second cycle of the phase onward; a pulse during the entry cycle is ignored.
  - On player_finished_in: if enemy_defeated_in = 1 -> RESULT with win (01). Otherwise -> ENEMY with phase_start_out pulse.
- ENEMY:
  - Same entry-cycle rule as PLAYER.
  - On enemy_finished_in, results are checked in this priority:
    - both defeated inputs set -> draw (11)
    - player_defeated_in only -> lose (10)
    - enemy_defeated_in only -> win (01)
    - turn_out + 1 == MAX_TURNS -> draw (11), turn_out := MAX_TURNS
  - If none of these apply: turn_out := turn_out + 1 -> PLAYER with phase_start_out pulse.
- RESULT: state and result held. start_in -> TITLE, and result_out stays until the next TITLE exit.
- Finished pulses from the non-active block, and start_in outside TITLE/RESULT, are ignored.
- busy inputs are status only; they never cause a transition.
- turn_out never wraps; the maximum value is MAX_TURNS.
- pixel_out is the pixel_in of the phase shown by state_out in the same cycle, registered. Latency is 1 cycle; sub-block pixel inputs must be aligned to the same hcount/vcount.

Optional Feature:
- Macro: PHASE_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on phase entry and counts each cycle in PLAYER or ENEMY.
  - When it reaches TIMEOUT_CYCLES-1 with no finished pulse, the phase is treated as finished in that cycle (same transition rules) and timeout_out := 1.
  - A finished pulse in the same cycle takes the normal path; timeout_out is not set.
- Undefined: no counter; phases wait indefinitely; timeout_out is tied 0.

Test Plan:
- Reset then start_in pulse -> state_out goes 0000 then 0001 next cycle, phase_start_out high exactly 1 cycle, turn_out = 0.
- Player finish, then enemy finish with no defeats -> state_out 0001 -> 1000 -> 0001, turn_out = 1; a player_finished_in pulse during ENEMY causes no change.
- Player finish with enemy_defeated_in = 1 -> RESULT, result_out = 01; then start_in -> TITLE, and the next start clears result_out to 00.
- MAX_TURNS = 3, three full rounds with no defeats -> RESULT, result_out = 11, turn_out = 3.
- Enemy finish with both defeated inputs high -> result_out = 11. Rst asserted mid-ENEMY -> all outputs at reset values the next cycle.
- PHASE_TIMEOUT_EN with TIMEOUT_CYCLES = 16, no finished pulse in PLAYER -> enters ENEMY 16 cycles after entry, timeout_out = 1. Pixel check: enemy_pixel_in = 12'hF00 in ENEMY -> pixel_out = 12'hF00 one cycle later.
